fetch_controller: RTL and testbench



---
 rtl/fetch_controller.sv | 108 ++++++++++
 tb/tb_fetch_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Multi-cycle PC sequencer: FETCH -> WAIT_MEM -> DECODE -> EXEC, stopping on HALT_OPCODE.
// Define SINGLE_STEP_EN to add the step port and a STEP_WAIT pause after each instruction.
module fetch_controller #(
   parameter int                 PC_W        = 32,
   parameter int                 INSTR_W     = 9,
   parameter int                 PC_STEP     = 4,
   parameter logic [PC_W-1:0]    RESET_PC    = '0,
   parameter logic [INSTR_W-1:0] HALT_OPCODE = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   input  logic               exec_done,
   input  logic               branch,
   input  logic               zero,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    pc,
   output logic               busy,
   output logic               done
`ifdef SINGLE_STEP_EN
   ,
   input  logic               step
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_MEM,
      DECODE,
      EXEC,
      HALT
`ifdef SINGLE_STEP_EN
      ,
      STEP_WAIT
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               pc_d    = RESET_PC;
               state_d = FETCH;
            end
         end
         FETCH: state_d = WAIT_MEM;
         WAIT_MEM: begin
            // A HALT word is still latched so the decoder sees what stopped the core.
            if (imem_valid) begin
               instr_d = imem_instr;
               state_d = (imem_instr == HALT_OPCODE) ? HALT : DECODE;
            end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            if (exec_done) begin
               pc_d = (branch && zero) ? branch_target : pc_q + PC_W'(PC_STEP);
`ifdef SINGLE_STEP_EN
               state_d = STEP_WAIT;
`else
               state_d = FETCH;
`endif
            end
         end
`ifdef SINGLE_STEP_EN
         STEP_WAIT: begin
            if (step) state_d = FETCH;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr_out   = instr_q;
   assign instr_valid = (state_q == DECODE);
   assign busy        = (state_q != IDLE) && (state_q != HALT);
   assign done        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller; a second instance covers a wrapping RESET_PC.
// Build with SINGLE_STEP_EN defined to also exercise the step pause.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset, start, imem_valid, exec_done, branch, zero;
   logic [8:0]  imem_instr;
   logic [31:0] branch_target;
   logic        imem_req, instr_valid, busy, done;
   logic [31:0] imem_addr, pc;
   logic [8:0]  instr_out;

   logic        w_reset, w_start, w_imem_valid, w_exec_done;
   logic [8:0]  w_imem_instr;
   logic        w_imem_req, w_instr_valid, w_busy, w_done;
   logic [31:0] w_imem_addr, w_pc;
   logic [8:0]  w_instr_out;
`ifdef SINGLE_STEP_EN
   logic        step, w_step;
`endif

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   fetch_controller dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_instr(imem_instr),
      .instr_out(instr_out), .instr_valid(instr_valid),
      .exec_done(exec_done), .branch(branch), .zero(zero),
      .branch_target(branch_target),
      .pc(pc), .busy(busy), .done(done)
`ifdef SINGLE_STEP_EN
      , .step(step)
`endif
   );

   fetch_controller #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .reset(w_reset), .start(w_start),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_valid(w_imem_valid), .imem_instr(w_imem_instr),
      .instr_out(w_instr_out), .instr_valid(w_instr_valid),
      .exec_done(w_exec_done), .branch(1'b0), .zero(1'b0),
      .branch_target(32'h0),
      .pc(w_pc), .busy(w_busy), .done(w_done)
`ifdef SINGLE_STEP_EN
      , .step(w_step)
`endif
   );

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Runs one non-HALT instruction starting from FETCH and returns in the next FETCH.
   task automatic runInstr(input logic [8:0] instr, input logic br, input logic z, input logic [31:0] tgt);
      applyStimulus();
      imem_valid = 1'b1;
      imem_instr = instr;
      applyStimulus();
      imem_valid = 1'b0;
      checkOutput("instr_valid_pulse", instr_valid, 1);
      checkOutput("instr_out_latched", instr_out, instr);
      applyStimulus();
      checkOutput("instr_valid_single", instr_valid, 0);
      exec_done     = 1'b1;
      branch        = br;
      zero          = z;
      branch_target = tgt;
      applyStimulus();
      exec_done = 1'b0;
      branch    = 1'b0;
      zero      = 1'b0;
`ifdef SINGLE_STEP_EN
      checkOutput("step_no_req", imem_req, 0);
      applyStimulus();
      checkOutput("step_still_no_req", imem_req, 0);
      checkOutput("step_busy", busy, 1);
      step = 1'b1;
      applyStimulus();
      step = 1'b0;
`endif
      checkOutput("fetch_req", imem_req, 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_instr = '0;
      exec_done = 1'b0; branch = 1'b0; zero = 1'b0; branch_target = '0;
      w_reset = 1'b1; w_start = 1'b0; w_imem_valid = 1'b0; w_imem_instr = '0; w_exec_done = 1'b0;
`ifdef SINGLE_STEP_EN
      step = 1'b0; w_step = 1'b0;
`endif

      $display("[TB] reset behaviour");
      for (int i = 0; i < 4; i++) begin
         if (i == 2) reset = 1'b0;
         applyStimulus();
         checkOutput("idle_pc", pc, 32'h0);
         checkOutput("idle_busy", busy, 0);
         checkOutput("idle_done", done, 0);
         checkOutput("idle_req", imem_req, 0);
         checkOutput("idle_instr_out", instr_out, 0);
      end

      $display("[TB] straight-line program ending in HALT");
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("start_req", imem_req, 1);
      checkOutput("start_addr", imem_addr, 32'h0);
      checkOutput("start_busy", busy, 1);
      applyStimulus();
      checkOutput("wait_no_req", imem_req, 0);
      imem_valid = 1'b1;
      imem_instr = 9'h001;
      applyStimulus();
      imem_valid = 1'b0;
      checkOutput("first_instr_valid", instr_valid, 1);
      checkOutput("first_instr_out", instr_out, 9'h001);
      applyStimulus();
      exec_done = 1'b1;
      applyStimulus();
      exec_done = 1'b0;
`ifdef SINGLE_STEP_EN
      checkOutput("first_step_no_req", imem_req, 0);
      step = 1'b1;
      applyStimulus();
      step = 1'b0;
`endif
      checkOutput("second_addr", imem_addr, 32'h4);
      runInstr(9'h002, 1'b0, 1'b0, 32'h0);
      checkOutput("third_addr", imem_addr, 32'h8);
      applyStimulus();
      imem_valid = 1'b1;
      imem_instr = 9'h1FF;
      applyStimulus();
      imem_valid = 1'b0;
      checkOutput("halt_done", done, 1);
      checkOutput("halt_pc", pc, 32'h8);
      checkOutput("halt_busy", busy, 0);
      checkOutput("halt_no_pulse", instr_valid, 0);
      exec_done = 1'b1;
      applyStimulus();
      exec_done = 1'b0;
      checkOutput("halt_ignores_exec_done", pc, 32'h8);
      checkOutput("halt_stays", done, 1);
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("restart_done_drops", done, 0);
      checkOutput("restart_req", imem_req, 1);
      checkOutput("restart_addr", imem_addr, 32'h0);

      $display("[TB] branch resolution");
      runInstr(9'h011, 1'b0, 1'b0, 32'h0);
      runInstr(9'h012, 1'b0, 1'b0, 32'h0);
      runInstr(9'h013, 1'b0, 1'b0, 32'h0);
      runInstr(9'h014, 1'b0, 1'b0, 32'h0);
      checkOutput("reach_0x10", imem_addr, 32'h10);
      runInstr(9'h015, 1'b1, 1'b1, 32'h40);
      checkOutput("taken_branch", imem_addr, 32'h40);
      runInstr(9'h016, 1'b1, 1'b1, 32'h10);
      checkOutput("taken_back", imem_addr, 32'h10);
      runInstr(9'h017, 1'b1, 1'b0, 32'h80);
      checkOutput("not_taken_zero0", imem_addr, 32'h14);
      runInstr(9'h018, 1'b0, 1'b1, 32'h80);
      checkOutput("not_taken_branch0", imem_addr, 32'h18);

      $display("[TB] reset during WAIT_MEM");
      applyStimulus();
      reset      = 1'b1;
      imem_valid = 1'b1;
      imem_instr = 9'h003;
      applyStimulus();
      reset      = 1'b0;
      imem_valid = 1'b0;
      checkOutput("midreset_no_pulse", instr_valid, 0);
      checkOutput("midreset_pc", pc, 32'h0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_instr_out", instr_out, 0);
      applyStimulus();
      checkOutput("midreset_stays_idle", busy, 0);
      checkOutput("midreset_no_pulse_later", instr_valid, 0);
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("midreset_restart_addr", imem_addr, 32'h0);
      runInstr(9'h004, 1'b0, 1'b0, 32'h0);
      checkOutput("midreset_next_addr", imem_addr, 32'h4);

      $display("[TB] PC wrap from RESET_PC=FFFFFFFC");
      w_reset = 1'b0;
      applyStimulus();
      checkOutput("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);
      w_start = 1'b1;
      applyStimulus();
      w_start = 1'b0;
      checkOutput("wrap_start_req", w_imem_req, 1);
      checkOutput("wrap_start_addr", w_imem_addr, 32'hFFFF_FFFC);
      applyStimulus();
      w_imem_valid = 1'b1;
      w_imem_instr = 9'h00A;
      applyStimulus();
      w_imem_valid = 1'b0;
      checkOutput("wrap_instr_valid", w_instr_valid, 1);
      applyStimulus();
      w_exec_done = 1'b1;
      applyStimulus();
      w_exec_done = 1'b0;
`ifdef SINGLE_STEP_EN
      checkOutput("wrap_step_pc", w_pc, 32'h0);
      checkOutput("wrap_step_no_req", w_imem_req, 0);
      w_step = 1'b1;
      applyStimulus();
      w_step = 1'b0;
`endif
      checkOutput("wrap_pc", w_pc, 32'h0);
      checkOutput("wrap_addr", w_imem_addr, 32'h0);
      checkOutput("wrap_req", w_imem_req, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
